syshdwtp_memoire_ctrl: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It replaces the fixed 32-bit, 16384-word, zero-wait memory with configurable width, depth and read latency. It adds explicit `readdatavalid` and `waitrequest` and an optional hardware zero-clear sequence after reset. It sits on the system interconnect as the processor's program/data memory.

---
 rtl/syshdwtp_memoire_ctrl.sv | 145 ++++++++++++++
 tb/tb_syshdwtp_memoire_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syshdwtp_memoire_ctrl.sv
// Single-port on-chip RAM behind an Avalon-MM slave: byte-lane writes, 1- or 2-cycle
// pipelined reads, clock-enable stall, and an optional zero-clear sweep after reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RESET | reset_n low or first edge after it; first clear write lands here
// ST_CLEAR | zeroing words 1 .. DEPTH-1, one per enabled cycle
// ST_READY | accepting Avalon commands
module syshdwtp_memoire_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               clr_we;

    logic               cmd_acc, wr_acc, rd_acc, in_range;
    logic [IDX_W-1:0]   cmd_idx;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [NB-1:0]      mem_be;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               s1_v_q;
    logic [DATA_W-1:0]  s1_data_q;

    assign waitrequest = (state_q != ST_READY) | ~clken;
    assign init_done   = (state_q == ST_READY);

    assign in_range = ({1'b0, address} < DEPTH_W);
    assign cmd_idx  = address[IDX_W-1:0];
    assign cmd_acc  = chipselect & (read | write) & ~waitrequest;
    assign wr_acc   = cmd_acc & write;
    // A simultaneous read+write is treated as a pure write.
    assign rd_acc   = cmd_acc & read & ~write;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (clken && (state_q != ST_READY)) begin
            if (CLEAR_ON_RESET == 0) begin
                state_d = ST_READY;
            end else begin
                clr_we = 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        mem_we    = clr_we | (wr_acc & in_range);
        mem_idx   = clr_we ? clr_cnt_q : cmd_idx;
        mem_be    = clr_we ? '1 : byteenable;
        mem_wdata = clr_we ? '0 : writedata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
        end else if (clken) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            s1_v_q    <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= in_range ? mem[cmd_idx] : '0;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic               out_v_q;
            logic [DATA_W-1:0]  out_data_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_v_q    <= 1'b0;
                    out_data_q <= '0;
                end else if (clken) begin
                    out_v_q <= s1_v_q;
                    if (s1_v_q) begin
                        out_data_q <= s1_data_q;
                    end
                end
            end

            assign readdatavalid = out_v_q;
            assign readdata      = out_data_q;
        end else begin : g_lat1
            assign readdatavalid = s1_v_q;
            assign readdata      = s1_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_syshdwtp_memoire_ctrl.sv
// Bench for syshdwtp_memoire_ctrl: two instances (read latency 1 and 2) share stimulus
// and are compared every cycle against a cycle-count/array reference model.
module tb_syshdwtp_memoire_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 16;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;

    logic [DW-1:0] rdata1, rdata2;
    logic          rdv1, rdv2, wreq1, wreq2, idone1, idone2;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [DW-1:0] m_mem [DP];
    int            en_edges;
    bit            now_v, prev_v;
    logic [DW-1:0] now_d, prev_d;
    bit            e1v, e2v;
    logic [DW-1:0] e1d, e2d;

    syshdwtp_memoire_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(rdata1), .readdatavalid(rdv1),
        .waitrequest(wreq1), .init_done(idone1)
    );

    syshdwtp_memoire_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(rdata2), .readdatavalid(rdv2),
        .waitrequest(wreq2), .init_done(idone2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        en_edges = 0;
        now_v = 1'b0; prev_v = 1'b0;
        now_d = '0;   prev_d = '0;
        e1v = 1'b0;   e2v = 1'b0;
        e1d = '0;     e2d = '0;
    endfunction

    // Memory is ready once DP enabled edges have elapsed since reset.
    function automatic void model_edge();
        bit ready;
        if (!reset_n || !clken) return;
        ready  = (en_edges >= DP);
        prev_v = now_v;
        prev_d = now_d;
        now_v  = 1'b0;
        if (!ready) begin
            m_mem[en_edges] = '0;
        end else if (chipselect && (read || write)) begin
            if (write) begin
                if (address < DP) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) m_mem[address[3:0]][8*b +: 8] = writedata[8*b +: 8];
                end
            end else begin
                now_v = 1'b1;
                now_d = (address < DP) ? m_mem[address[3:0]] : 32'h0;
            end
        end
        en_edges++;
        e1v = now_v;
        if (now_v) e1d = now_d;
        e2v = prev_v;
        if (prev_v) e2d = prev_d;
    endfunction

    task automatic chk_all();
        bit ready;
        ready = reset_n && (en_edges >= DP);
        chk("rdv_l1",   {31'b0, rdv1},   {31'b0, e1v});
        chk("rdata_l1", rdata1,          e1d);
        chk("wreq_l1",  {31'b0, wreq1},  {31'b0, !(ready && clken)});
        chk("idone_l1", {31'b0, idone1}, {31'b0, ready});
        chk("rdv_l2",   {31'b0, rdv2},   {31'b0, e2v});
        chk("rdata_l2", rdata2,          e2d);
        chk("wreq_l2",  {31'b0, wreq2},  {31'b0, !(ready && clken)});
        chk("idone_l2", {31'b0, idone2}, {31'b0, ready});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic cmd(input bit r, input bit w, input int a, input logic [3:0] be,
                       input logic [31:0] d);
        chipselect = 1'b1;
        read       = r;
        write      = w;
        address    = AW'(a);
        byteenable = be;
        writedata  = d;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!idone1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        clken      = 1'b1;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        idle();
        for (int i = 0; i < DP; i++) m_mem[i] = 'x;
        #2;
        model_reset();
        chk_all();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(n);
        chk("clear_cycles_first", n, 16);

        // preload, then reset and confirm the sweep zeroes every word
        for (int i = 0; i < DP; i++) begin
            cmd(0, 1, i, 4'hF, 32'hDEADBEEF);
            tick();
        end
        idle();
        tick();
        assert_reset();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(n);
        chk("clear_cycles_after_preload", n, 16);
        for (int i = 0; i < DP; i++) begin
            cmd(1, 0, i, 4'h0, '0);
            tick();
            chk("cleared_word", rdata1, 32'h0);
        end
        idle();
        tick();
        tick();

        // byte-lane write over a zeroed word
        cmd(0, 1, 5, 4'b0101, 32'hAABBCCDD);
        tick();
        cmd(1, 0, 5, 4'h0, '0);
        tick();
        chk("be_word_l1", rdata1, 32'h00BB00DD);
        chk("be_l2_not_yet", {31'b0, rdv2}, 32'h0);
        idle();
        tick();
        chk("be_l2_valid", {31'b0, rdv2}, 32'h1);
        chk("be_word_l2", rdata2, 32'h00BB00DD);

        // back-to-back reads of distinct words
        for (int i = 0; i < 4; i++) begin
            cmd(0, 1, i, 4'hF, 32'h1111_1111 * (i + 1));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            cmd(1, 0, i, 4'h0, '0);
            tick();
            chk("b2b_data", rdata1, 32'h1111_1111 * (i + 1));
        end
        idle();
        tick();
        tick();

        // simultaneous read+write behaves as a write only
        cmd(1, 1, 2, 4'hF, 32'h12345678);
        tick();
        chk("rw_no_valid", {31'b0, rdv1}, 32'h0);
        cmd(1, 0, 2, 4'h0, '0);
        tick();
        chk("rw_readback", rdata1, 32'h12345678);
        idle();
        tick();
        tick();

        // randomized traffic, including out-of-range addresses and stalls
        for (int i = 0; i < 400; i++) begin
            chipselect = ($urandom_range(0, 9) < 8);
            read       = $urandom_range(0, 1);
            write      = ($urandom_range(0, 2) == 0);
            address    = AW'($urandom_range(0, 31));
            byteenable = 4'($urandom);
            writedata  = $urandom;
            clken      = ($urandom_range(0, 9) != 0);
            tick();
        end
        idle();
        clken = 1'b1;
        tick();
        tick();

        // clken stall in the middle of the clear
        assert_reset();
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (7) begin tick(); n++; end
        clken = 1'b0;
        repeat (3) begin tick(); n++; end
        chk("stall_wreq_held", {31'b0, wreq1}, 32'h1);
        clken = 1'b1;
        while (!idone1 && n < 100) begin tick(); n++; end
        chk("stall_clear_cycles", n, 19);

        // reset one cycle after a latency-2 read is accepted
        cmd(0, 1, 0, 4'hF, 32'hCAFE0001);
        tick();
        cmd(0, 1, 3, 4'hF, 32'hCAFE0003);
        tick();
        cmd(1, 0, 3, 4'h0, '0);
        tick();
        assert_reset();
        idle();
        chk("rst_rdv_l2", {31'b0, rdv2}, 32'h0);
        chk("rst_rdata_l2", rdata2, 32'h0);
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(n);
        chk("clear_cycles_restart", n, 16);
        cmd(1, 0, 0, 4'h0, '0);
        tick();
        chk("restart_word0", rdata1, 32'h0);
        cmd(1, 0, 3, 4'h0, '0);
        tick();
        chk("restart_word3", rdata1, 32'h0);
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
